mult_div_unit: RTL
==================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, meaning the number of Busy cycles for mult and multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, meaning the number of Busy cycles for div and divu.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port A, input, 32 bits, EX-stage forwarded rs operand.
REQ-006 SHALL have port B, input, 32 bits, EX-stage forwarded rt operand.
REQ-007 SHALL have port MDOp, input, 4 bits, operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9-15 none.
REQ-008 SHALL have port Start, input, 1 bit, qualifies MDOp as a valid EX-stage instruction this cycle.
REQ-009 SHALL have port Busy, output, 1 bit, high while a multiply/divide is in flight; the hazard unit ORs (Start|Busy) into its Allstall term.
REQ-010 SHALL have port HI, output, 32 bits, architectural HI register.
REQ-011 SHALL have port LO, output, 32 bits, architectural LO register.
REQ-012 SHALL have port MDout, output, 32 bits, the read result for mfhi/mflo.

Function
REQ-013 SHALL treat an operation as accepted only when Start=1 and Busy=0 at a rising edge; Start while Busy=1 SHALL be ignored entirely, including mthi/mtlo.
REQ-014 SHALL, on an accepted mult/multu/div/divu at edge k, latch both operands and op, load a cycle counter with N (MULT_CYCLES or DIV_CYCLES), and drive Busy=1 from edge k through edge k+N.
REQ-015 SHALL decrement the counter once per cycle while Busy=1; at edge k+N it SHALL write HI/LO and clear Busy in the same edge.
REQ-016 SHALL keep HI/LO holding their prior values for the whole Busy window; the new values SHALL be visible only after edge k+N.
REQ-017 SHALL compute mult as signed 32x32->64 and multu as unsigned, with HI = bits 63:32 and LO = bits 31:0.
REQ-018 SHALL compute div/divu as LO = quotient, HI = remainder, signed (truncate toward zero, remainder takes the dividend's sign) or unsigned respectively.
REQ-019 SHALL, for divisor B=0, still run the full DIV_CYCLES Busy window and leave HI and LO unchanged.
REQ-020 SHALL, for signed 0x80000000 / 0xFFFFFFFF, produce LO=0x80000000 and HI=0x00000000.
REQ-021 SHALL, on an accepted mthi/mtlo, write A into HI/LO respectively at that edge, with no Busy cycle.
REQ-022 SHALL drive MDout combinationally: HI when MDOp=7, LO when MDOp=8, otherwise 0, regardless of Start and Busy.
REQ-023 SHALL treat MDOp 0, 7, 8 and 9-15 with Start=1 as having no state effect.
REQ-024 SHALL operate with operands latched at acceptance, so A/B changes during Busy have no effect on the result.

Reset
REQ-025 SHALL, when reset=1 at a rising edge, set HI=0, LO=0, Busy=0, and the counter and latched operands to 0, overriding any Start in the same cycle.
REQ-026 SHALL, on reset during a Busy window, abort the operation, discard its result, and leave HI/LO=0 after the edge.

Verification
REQ-027 SHALL be verified by: mult A=0xFFFFFFFF, B=2 with Start at edge 0 -> Busy=1 for edges 0-4, then HI=0xFFFFFFFF, LO=0xFFFFFFFE at edge 5 with Busy=0; multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-028 SHALL be verified by: div A=-7 (0xFFFFFFF9), B=2 -> after 10 Busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=0 -> 10 Busy cycles, then HI/LO unchanged.
REQ-029 SHALL be verified by: mthi A=0x12345678, then MDOp=7 -> HI=0x12345678 one edge later, MDout=0x12345678, Busy never asserted.
REQ-030 SHALL be verified by: mult started, then Start with mtlo A=0xDEAD at Busy cycle 2 -> mtlo ignored, and LO after completion equals the product low word.
REQ-031 SHALL be verified by: reset=1 asserted at Busy cycle 3 of a div -> next edge Busy=0, HI=LO=0, and no late write-back occurs.
REQ-032 SHALL be verified by: Start with mult on the edge at which the previous div completes (Busy was 1) -> mult ignored; the same Start one cycle later is accepted.

Source files
------------

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle MIPS-style multiply/divide unit with HI/LO registers
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDout
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  localparam logic [15:0] MULT_N = 16'(MULT_CYCLES);
  localparam logic [15:0] DIV_N  = 16'(DIV_CYCLES);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [3:0]  op_q, op_n;
  logic [31:0] a_q, a_n;
  logic [31:0] b_q, b_n;
  logic [31:0] hi_q, hi_n;
  logic [31:0] lo_q, lo_n;

  // Arithmetic on the latched operands only, so EX-stage operand changes during Busy are harmless.
  logic [63:0] prod_s, prod_u;
  logic        div_signed;
  logic [31:0] dvd_mag, dvs_mag, q_mag, r_mag, quo, rem;

  // Products and a shared magnitude divider; signed divide negates afterwards so
  // 0x80000000 / -1 wraps to 0x80000000 instead of relying on signed overflow.
  always_comb begin
    prod_s     = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u     = {32'd0, a_q} * {32'd0, b_q};
    div_signed = (op_q == OP_DIV);
    dvd_mag    = (div_signed && a_q[31]) ? (32'd0 - a_q) : a_q;
    dvs_mag    = (div_signed && b_q[31]) ? (32'd0 - b_q) : b_q;
    q_mag      = (dvs_mag != 32'd0) ? (dvd_mag / dvs_mag) : 32'd0;
    r_mag      = (dvs_mag != 32'd0) ? (dvd_mag % dvs_mag) : 32'd0;
    quo        = (div_signed && (a_q[31] ^ b_q[31])) ? (32'd0 - q_mag) : q_mag;
    rem        = (div_signed && a_q[31]) ? (32'd0 - r_mag) : r_mag;
  end

  // Next-state logic: accept only from idle, count down while busy, write back on the last edge.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_n    = op_q;
    a_n     = a_q;
    b_n     = b_q;
    hi_n    = hi_q;
    lo_n    = lo_q;
    case (state)
      S_IDLE: begin
        if (Start) begin
          case (MDOp)
            OP_MULT, OP_MULTU: begin
              op_n    = MDOp;
              a_n     = A;
              b_n     = B;
              cnt_n   = MULT_N;
              state_n = S_BUSY;
            end
            OP_DIV, OP_DIVU: begin
              op_n    = MDOp;
              a_n     = A;
              b_n     = B;
              cnt_n   = DIV_N;
              state_n = S_BUSY;
            end
            OP_MTHI: hi_n = A;
            OP_MTLO: lo_n = A;
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        if (cnt <= 16'd1) begin
          state_n = S_IDLE;
          cnt_n   = 16'd0;
          case (op_q)
            OP_MULT: begin
              hi_n = prod_s[63:32];
              lo_n = prod_s[31:0];
            end
            OP_MULTU: begin
              hi_n = prod_u[63:32];
              lo_n = prod_u[31:0];
            end
            OP_DIV, OP_DIVU: begin
              // A zero divisor still burns the full window but leaves HI/LO alone.
              if (b_q != 32'd0) begin
                hi_n = rem;
                lo_n = quo;
              end
            end
            default: ;
          endcase
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State register; reset wins over any Start and discards an in-flight result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 16'd0;
      op_q  <= 4'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      op_q  <= op_n;
      a_q   <= a_n;
      b_q   <= b_n;
      hi_q  <= hi_n;
      lo_q  <= lo_n;
    end
  end

  // Read port is purely combinational on MDOp so mfhi/mflo see HI/LO in the same cycle.
  always_comb begin
    Busy  = (state == S_BUSY);
    HI    = hi_q;
    LO    = lo_q;
    MDout = 32'd0;
    if (MDOp == OP_MFHI) MDout = hi_q;
    else if (MDOp == OP_MFLO) MDout = lo_q;
  end

endmodule
